// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: ping-pong framer that bursts 64-sample complex frames into a pipelined FFT.
// Optional status counters (frames_sent, drop_cnt) are enabled by defining FFT_FEEDER_STATUS_EN.
module fft_frame_feeder #(
   parameter int DW  = 12,
   parameter int AW  = 6,
   parameter int GAP = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic signed [DW-1:0] s_r,
   input  logic signed [DW-1:0] s_i,
   input  logic                 flush,
   output logic                 in_valid,
   output logic signed [DW-1:0] din_r,
   output logic signed [DW-1:0] din_i,
   output logic                 frame_start,
   output logic                 busy
`ifdef FFT_FEEDER_STATUS_EN
   ,
   output logic [15:0]          frames_sent,
   output logic [15:0]          drop_cnt
`endif
);
   localparam int N = 1 << AW;
   typedef enum logic [1:0] {IDLE, STREAM, GAPS} state_t;
   logic [2*DW-1:0] mem [2*N];
   logic [1:0] full;
   logic wr_sel, rd_sel, alive, wr_en, wr_last, rd_en, rd_last, next_full;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [15:0] gap_cnt;
   state_t state, state_n;
   // alive holds s_ready low until the first edge after reset release
   assign s_ready = alive & ~full[wr_sel];
   assign wr_en   = s_valid & s_ready & ~flush;
   assign wr_last = wr_en & (&wr_ptr);
   assign rd_last = rd_en & (&rd_ptr);
   assign busy    = (|full) | (state != IDLE);
   // the other bank counts as full if its last sample lands on this same edge, keeping bursts seamless
   assign next_full = full[~rd_sel] | (wr_last & (wr_sel != rd_sel));
   // read FSM next state and address issue
   always_comb begin
      state_n = state;
      rd_en   = 1'b0;
      case (state)
         IDLE:    state_n = full[rd_sel] ? STREAM : IDLE;
         STREAM: begin
            rd_en = 1'b1;
            if (&rd_ptr) state_n = (GAP > 0) ? GAPS : (next_full ? STREAM : IDLE);
         end
         GAPS:    if (gap_cnt == 16'(GAP - 1)) state_n = full[rd_sel] ? STREAM : IDLE;
         default: state_n = IDLE;
      endcase
   end
   // control registers: bank flags, pointers, bank selects, FSM state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         full    <= '0;
         wr_sel  <= 1'b0;
         rd_sel  <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         gap_cnt <= '0;
         alive   <= 1'b0;
      end else begin
         alive   <= 1'b1;
         state   <= state_n;
         full    <= (full | (2'(wr_last) << wr_sel)) & ~(2'(rd_last) << rd_sel);
         wr_ptr  <= flush ? '0 : (wr_en ? wr_ptr + 1'b1 : wr_ptr);
         wr_sel  <= wr_last ? ~wr_sel : wr_sel;
         rd_sel  <= rd_last ? ~rd_sel : rd_sel;
         rd_ptr  <= rd_en ? rd_ptr + 1'b1 : '0;
         gap_cnt <= (state == GAPS) ? gap_cnt + 16'd1 : '0;
      end
   end
   // sample storage, both banks in one array indexed by {bank, address}
   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_sel, wr_ptr}] <= {s_r, s_i};
   end
   // registered FFT-side outputs; din holds its last value between bursts
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_valid    <= 1'b0;
         frame_start <= 1'b0;
         din_r       <= '0;
         din_i       <= '0;
      end else begin
         in_valid    <= rd_en;
         frame_start <= rd_en & (rd_ptr == '0);
         if (rd_en) {din_r, din_i} <= mem[{rd_sel, rd_ptr}];
      end
   end
`ifdef FFT_FEEDER_STATUS_EN
   // frame counter wraps, drop counter saturates
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frames_sent <= '0;
         drop_cnt    <= '0;
      end else begin
         if (frame_start) frames_sent <= frames_sent + 16'd1;
         if (flush && wr_ptr != '0 && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif
endmodule
